// File: rtl/common.sv
// Shared types and helpers for the reset generator.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package common;

    // Domain reset state machine.
    typedef enum logic [1:0] {
        HOLD  = 2'd0,
        COUNT = 2'd1,
        RUN   = 2'd2
    } reset_state_t;

    localparam int HOLD_CNT_W = 16;
    localparam int DB_CNT_W   = 20;

    // Saturating increment for the 8-bit reset event counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/cdc_sync.sv
// Multi-flop synchronizer bringing one asynchronous bit into clk_i.
// Latency: STAGES clk_i cycles from input change to sync_o.
// Backpressure: none; free-running level synchronizer.
module cdc_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic async_i,
    output logic sync_o
);

    // Initial value matches the reset value so un-reset simulation starts at 0.
    logic [STAGES-1:0] chain = '0;

    // Shift the asynchronous level through the flop chain.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], async_i};
        end
    end

    assign sync_o = chain[STAGES-1];

endmodule

// File: rtl/reset_gen.sv
// Domain reset generator: holds reset_o until PLL lock is stable and the button is idle.
// Latency: reset_o falls HOLD_CYCLES+1 cycles after the synchronized lock is first sampled.
// Backpressure: none; optional button debounce enabled by macro RESET_BUTTON_DEBOUNCE_EN.
module reset_gen
    import common::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int HOLD_CYCLES     = 16,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       ready_async_i,
    input  logic       button_async_i,
    output logic       reset_o,
    output logic [7:0] reset_count_o
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_CYCLES - 1);

    // Reject illegal parameter values at elaboration.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("reset_gen: SYNC_STAGES out of range 2..4");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65535) begin : g_bad_hold
        $error("reset_gen: HOLD_CYCLES out of range 1..65535");
    end
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 1048575) begin : g_bad_db
        $error("reset_gen: DEBOUNCE_CYCLES out of range 1..2^20-1");
    end

    logic ready_sync;
    logic button_sync;
    logic button_db;

    cdc_sync #(.STAGES(SYNC_STAGES)) u_ready_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .async_i (ready_async_i),
        .sync_o  (ready_sync)
    );

    cdc_sync #(.STAGES(SYNC_STAGES)) u_button_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .async_i (button_async_i),
        .sync_o  (button_sync)
    );

`ifdef RESET_BUTTON_DEBOUNCE_EN
    localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [DB_CNT_W-1:0] db_cnt = '0;
    logic                db_q   = 1'b0;

    // Accept a new button level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            db_cnt <= '0;
            db_q   <= 1'b0;
        end else if (button_sync == db_q) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            db_q   <= button_sync;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end

    assign button_db = db_q;
`else
    assign button_db = button_sync;
`endif

    reset_state_t          state    = HOLD;
    logic [HOLD_CNT_W-1:0] hold_cnt = '0;
    logic                  reset_q  = 1'b1;
    logic [7:0]            count_q  = '0;

    // Reset state machine; reset_o is registered from the current state, so it
    // follows the state one cycle later and has no path from any input.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state    <= HOLD;
            hold_cnt <= '0;
            reset_q  <= 1'b1;
            count_q  <= '0;
        end else begin
            reset_q <= (state != RUN);
            case (state)
                HOLD: begin
                    if (ready_sync && !button_db) begin
                        state    <= COUNT;
                        hold_cnt <= '0;
                    end
                end
                COUNT: begin
                    hold_cnt <= hold_cnt + 1'b1;
                    // Losing lock or a button press beats a completed count.
                    if (!ready_sync || button_db) begin
                        state <= HOLD;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!ready_sync || button_db) begin
                        state   <= HOLD;
                        count_q <= sat_inc8(count_q);
                    end
                end
                default: state <= HOLD;
            endcase
        end
    end

    assign reset_o       = reset_q;
    assign reset_count_o = count_q;

endmodule

// File: tb/tb_reset_gen.sv
// Directed bench for reset_gen with SYNC_STAGES=2, HOLD_CYCLES=4, DEBOUNCE_CYCLES=3.
// Each step drives inputs, pushes the expected outputs, then pops and compares after the edge.
module tb_reset_gen;

    logic       clk    = 1'b0;
    logic       reset  = 1'b0;
    logic       ready  = 1'b0;
    logic       button = 1'b0;
    logic       reset_o;
    logic [7:0] count_o;

    always #5 clk = ~clk;

    reset_gen #(
        .SYNC_STAGES     (2),
        .HOLD_CYCLES     (4),
        .DEBOUNCE_CYCLES (3)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .ready_async_i  (ready),
        .button_async_i (button),
        .reset_o        (reset_o),
        .reset_count_o  (count_o)
    );

    typedef struct packed {
        logic       rst;
        logic [7:0] cnt;
    } exp_t;

    exp_t       sb[$];
    int         checks    = 0;
    int         errors    = 0;
    logic [7:0] model_cnt = 8'd0;

    // Model of the saturating RUN->HOLD event counter.
    task automatic bump();
        model_cnt = (model_cnt == 8'hFF) ? model_cnt : model_cnt + 8'd1;
    endtask

    // Drive inputs before the next edge, expect reset_o/count after it.
    task automatic cyc(input logic r, input logic rdy, input logic btn,
                       input logic exp_rst, input string tag);
        exp_t e;
        reset  = r;
        ready  = rdy;
        button = btn;
        sb.push_back('{rst: exp_rst, cnt: model_cnt});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        checks++;
        assert (reset_o === e.rst) else begin
            errors++;
            $error("FAIL %s reset_o observed=%0b expected=%0b", tag, reset_o, e.rst);
        end
        checks++;
        assert (count_o === e.cnt) else begin
            errors++;
            $error("FAIL %s reset_count_o observed=%0d expected=%0d", tag, count_o, e.cnt);
        end
    endtask

    // Lock loss from RUN: seen by the FSM on the 3rd edge, reset_o high on the 4th.
    task automatic drop(input string tag);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, tag);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, tag);
        bump();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, tag);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, tag);
    endtask

    // Relock from HOLD with idle synchronizers: reset_o high for 7 edges, low on the 8th.
    task automatic relock(input string tag);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, (i < 7), tag);
    endtask

    initial begin
        // Reset state.
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, "reset");

        // Power-up: lock present before edge 0, reset_o low from edge 7.
        relock("powerup");

        // Lock loss in RUN, then relock.
        drop("lockloss");
        relock("relock");

        // Lock glitch at hold count 2: count restarts on re-entry.
        drop("glitch_loss");
        for (int i = 0; i < 12; i++) cyc(1'b0, (i != 3), 1'b0, (i < 11), "glitch");

`ifdef RESET_BUTTON_DEBOUNCE_EN
        // Short pulse is filtered out.
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, (i < 2), 1'b0, "btn_short");
        // Long pulse resets the domain.
        for (int i = 0; i < 16; i++) begin
            if (i == 5) bump();
            cyc(1'b0, 1'b1, (i < 5), (i >= 6 && i < 15), "btn_long");
        end
`else
        // Without debounce a 2-cycle pulse resets the domain.
        for (int i = 0; i < 10; i++) begin
            if (i == 2) bump();
            cyc(1'b0, 1'b1, (i < 2), (i >= 3 && i < 9), "btn_pulse");
        end
`endif

        // Saturation of the event counter.
        repeat (260) begin
            drop("sat_loss");
            relock("sat_relock");
        end
        checks++;
        assert (count_o === 8'd255) else begin
            errors++;
            $error("FAIL saturate reset_count_o observed=%0d expected=255", count_o);
        end

        // Reset in the middle of COUNT: back to reset values, then a full restart.
        drop("mid_loss");
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1, "mid_count");
        model_cnt = 8'd0;
        cyc(1'b1, 1'b1, 1'b0, 1'b1, "mid_reset");
        relock("restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
